// File: rtl/wb_defs.sv
// Shared Wishbone definitions: bus widths, FSM encoding and the registered bus payload.
package wb_defs;

    localparam int unsigned WB_DAT_W      = 32;
    localparam int unsigned WB_ADR_W      = 32;
    localparam int unsigned WB_SEL_W      = 4;
    localparam int unsigned WB_WORD_BYTES = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } wbm_state_e;

    typedef struct packed {
        logic                cyc;
        logic                stb;
        logic                we;
        logic                tga;
        logic [WB_SEL_W-1:0] sel;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
    } wb_bus_t;

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Per-beat ack timeout counter. Only built when WBM_TIMEOUT_EN is defined.
`ifdef WBM_TIMEOUT_EN
module wbm_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expires during the LIMIT-th consecutive enabled cycle without a clear.
    assign expired_c = (cnt_q == CNT_W'(LIMIT - 1));

    // Next count: clear wins, saturate at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/wb_burst_master.sv
// Wishbone classic burst initiator: one command (1..2**MAX_LEN_W beats) at a time,
// one rsp_valid_o pulse per completed beat. WBM_TIMEOUT_EN adds a per-beat ack timeout.
module wb_burst_master
    import wb_defs::*;
#(
    parameter int unsigned MAX_LEN_W   = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [WB_ADR_W-1:0]  req_adr_i,
    input  logic [WB_DAT_W-1:0]  req_dat_i,
    input  logic [WB_SEL_W-1:0]  req_sel_i,
    input  logic                 req_tga_i,
    input  logic [MAX_LEN_W-1:0] req_len_i,
    output logic                 rsp_valid_o,
    output logic [WB_DAT_W-1:0]  rsp_dat_o,
    output logic                 rsp_last_o,
    output logic                 rsp_err_o,
    output logic [WB_ADR_W-1:0]  wb_adr_o,
    output logic [WB_DAT_W-1:0]  wb_dat_o,
    input  logic [WB_DAT_W-1:0]  wb_dat_i,
    output logic                 wb_we_o,
    output logic                 wb_stb_o,
    output logic                 wb_cyc_o,
    output logic                 wb_tga_o,
    output logic [WB_SEL_W-1:0]  wb_sel_o,
    input  logic                 wb_ack_i
);

    localparam logic [WB_ADR_W-1:0] ADR_MASK = ~WB_ADR_W'(WB_WORD_BYTES - 1);
    localparam logic [WB_ADR_W-1:0] ADR_STEP = WB_ADR_W'(WB_WORD_BYTES);

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be nonzero");
    end

    wbm_state_e           state_q, state_d;
    wb_bus_t              bus_q, bus_d;
    logic [MAX_LEN_W-1:0] len_q, len_d;
    logic [MAX_LEN_W-1:0] beat_q, beat_d;
    logic                 ready_q, ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_last_q, rsp_last_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [WB_DAT_W-1:0]  rsp_dat_q, rsp_dat_d;
    logic                 accept_c;
    logic                 tmo_c;

    assign accept_c = (state_q == ST_IDLE) && req_i && ready_q;

`ifdef WBM_TIMEOUT_EN
    logic tmo_clr_c;
    logic tmo_en_c;
    logic tmo_expired_c;

    // Restart the window on every ack and whenever the bus is idle.
    assign tmo_clr_c = (state_q != ST_BUS) || wb_ack_i;
    assign tmo_en_c  = (state_q == ST_BUS);
    assign tmo_c     = (state_q == ST_BUS) && tmo_expired_c;

    wbm_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmo_clr_c),
        .en_i      (tmo_en_c),
        .expired_c (tmo_expired_c)
    );
`else
    assign tmo_c = 1'b0;
`endif

    // Next-state and registered-output logic; ack has priority over timeout.
    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        len_d       = len_q;
        beat_d      = beat_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = rsp_dat_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept_c) begin
                    bus_d.cyc = 1'b1;
                    bus_d.stb = 1'b1;
                    bus_d.we  = req_we_i;
                    bus_d.tga = req_tga_i;
                    bus_d.sel = req_sel_i;
                    bus_d.adr = req_adr_i & ADR_MASK;
                    bus_d.dat = req_dat_i;
                    len_d     = req_len_i;
                    beat_d    = '0;
                    ready_d   = 1'b0;
                    state_d   = ST_BUS;
                end
            end
            ST_BUS: begin
                ready_d = 1'b0;
                if (wb_ack_i) begin
                    rsp_valid_d = 1'b1;
                    if (!bus_q.we) begin
                        rsp_dat_d = wb_dat_i;
                    end
                    if (beat_q == len_q) begin
                        rsp_last_d = 1'b1;
                        bus_d.cyc  = 1'b0;
                        bus_d.stb  = 1'b0;
                        ready_d    = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_d    = beat_q + MAX_LEN_W'(1);
                        bus_d.adr = bus_q.adr + ADR_STEP;
                        bus_d.dat = req_dat_i;
                    end
                end else if (tmo_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    bus_d.cyc   = 1'b0;
                    bus_d.stb   = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            bus_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_last_o  = rsp_last_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign wb_cyc_o    = bus_q.cyc;
    assign wb_stb_o    = bus_q.stb;
    assign wb_we_o     = bus_q.we;
    assign wb_tga_o    = bus_q.tga;
    assign wb_sel_o    = bus_q.sel;
    assign wb_adr_o    = bus_q.adr;
    assign wb_dat_o    = bus_q.dat;

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: command-level model with an emulated Wishbone slave/RAM,
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_wb_burst_master;

`ifdef WBM_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif
    localparam int NOACK = 255;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        tga;
        logic [3:0]  len;
        logic [31:0] dseed;
        int          waitc;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_adr_i = '0;
    logic [31:0] req_dat_i = '0;
    logic [3:0]  req_sel_i = '0;
    logic        req_tga_i = 1'b0;
    logic [3:0]  req_len_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_last_o;
    logic        rsp_err_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_tga_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0;

    wb_burst_master #(
        .MAX_LEN_W   (4),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_i       (req_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_adr_i   (req_adr_i),
        .req_dat_i   (req_dat_i),
        .req_sel_i   (req_sel_i),
        .req_tga_i   (req_tga_i),
        .req_len_i   (req_len_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_last_o  (rsp_last_o),
        .rsp_err_o   (rsp_err_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_tga_o    (wb_tga_o),
        .wb_sel_o    (wb_sel_o),
        .wb_ack_i    (wb_ack_i)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;

    logic [31:0] mem [logic [31:0]];
    cmd_t        cmd_q [$];
    cmd_t        cur;
    bit          exp_cyc = 1'b0;
    bit          exp_valid = 1'b0;
    bit          exp_last = 1'b0;
    bit          exp_err = 1'b0;
    bit          exp_rd = 1'b0;
    logic [31:0] exp_dat = '0;
    int          beat_idx = 0;
    int          wait_cnt = 0;
    int          tmo_run = 0;
    bit          seen_edge = 1'b0;

    logic [31:0] obs_adr [$];
    int          cyc_cnt = 0;
    int          pulse_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] last_dat = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Untouched RAM words read back as a fixed function of their address.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = mem_rd(a);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        end
        mem[a] = w;
    endtask

    // First clock edge after reset release; req_ready_o must stay 0 until then.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) seen_edge <= 1'b0;
        else        seen_edge <= 1'b1;
    end

    // Per-cycle compare, slave emulation and command driver, all away from the active edge.
    always @(negedge clk) begin
        bit          busy_before;
        bit          ack;
        logic [31:0] ea;
        if (!rst_n) begin
            chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
            chk("rst_stb", 32'(wb_stb_o), 32'd0);
            chk("rst_valid", 32'(rsp_valid_o), 32'd0);
            chk("rst_ready", 32'(req_ready_o), 32'd0);
            exp_cyc   = 1'b0;
            exp_valid = 1'b0;
            beat_idx  = 0;
            wait_cnt  = 0;
            tmo_run   = 0;
            req_i     = 1'b0;
            wb_ack_i  = 1'b0;
        end else begin
            chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
            chk("rsp_last", 32'(rsp_last_o), 32'(exp_valid & exp_last));
            chk("rsp_err", 32'(rsp_err_o), 32'(exp_valid & exp_err));
            if (exp_valid && exp_rd) chk("rsp_dat", rsp_dat_o, exp_dat);
            if (rsp_valid_o) begin
                pulse_cnt++;
                if (rsp_err_o) err_cnt++;
                last_dat = rsp_dat_o;
            end
            chk("req_ready", 32'(req_ready_o), 32'(seen_edge && !exp_cyc));
            chk("wb_cyc", 32'(wb_cyc_o), 32'(exp_cyc));
            chk("wb_stb", 32'(wb_stb_o), 32'(exp_cyc));
            if (wb_cyc_o) cyc_cnt++;

            busy_before = exp_cyc;
            exp_valid   = 1'b0;
            exp_last    = 1'b0;
            exp_err     = 1'b0;
            exp_rd      = 1'b0;
            ack         = 1'b0;
            if (exp_cyc) begin
                ea = (cur.adr & 32'hFFFF_FFFC) + 32'(beat_idx * 4);
                chk("wb_adr", wb_adr_o, ea);
                chk("wb_we", 32'(wb_we_o), 32'(cur.we));
                chk("wb_sel", 32'(wb_sel_o), 32'(cur.sel));
                chk("wb_tga", 32'(wb_tga_o), 32'(cur.tga));
                if (cur.we) chk("wb_dat", wb_dat_o, cur.dseed + 32'(beat_idx));
                ack = (cur.waitc != NOACK) && (wait_cnt == cur.waitc);
                if (ack) begin
                    exp_valid = 1'b1;
                    exp_last  = (beat_idx == int'(cur.len));
                    exp_rd    = !cur.we;
                    exp_dat   = mem_rd(ea);
                    obs_adr.push_back(wb_adr_o);
                    if (wb_we_o) mem_wr(wb_adr_o, wb_dat_o, wb_sel_o);
                    wb_dat_i = mem_rd(wb_adr_o);
                    wait_cnt = 0;
                    tmo_run  = 0;
                    if (exp_last) exp_cyc = 1'b0;
                    else          beat_idx++;
                end else begin
                    wait_cnt++;
                    tmo_run++;
                    wb_dat_i = $urandom;
`ifdef WBM_TIMEOUT_EN
                    if (tmo_run == int'(TMO)) begin
                        exp_valid = 1'b1;
                        exp_last  = 1'b1;
                        exp_err   = 1'b1;
                        exp_cyc   = 1'b0;
                    end
`endif
                end
                wb_ack_i = ack;
            end else begin
                wb_ack_i = 1'($urandom_range(0, 1));
                wb_dat_i = $urandom;
            end

            req_dat_i = $urandom;
            req_we_i  = 1'($urandom_range(0, 1));
            req_adr_i = $urandom;
            req_sel_i = 4'($urandom);
            req_tga_i = 1'($urandom_range(0, 1));
            req_len_i = 4'($urandom);
            if (!busy_before && seen_edge && cmd_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                cur       = cmd_q.pop_front();
                req_i     = 1'b1;
                req_we_i  = cur.we;
                req_adr_i = cur.adr;
                req_sel_i = cur.sel;
                req_tga_i = cur.tga;
                req_len_i = cur.len;
                req_dat_i = cur.dseed;
                exp_cyc   = 1'b1;
                beat_idx  = 0;
                wait_cnt  = 0;
                tmo_run   = 0;
            end else if (busy_before) begin
                req_i = 1'($urandom_range(0, 1));
                if (ack && exp_cyc) req_dat_i = cur.dseed + 32'(beat_idx);
            end else begin
                req_i = 1'b0;
            end
        end
    end

    task automatic push(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic tga,
                        input logic [3:0] len, input logic [31:0] dseed, input int waitc);
        cmd_t c;
        c.we = we; c.adr = adr; c.sel = sel; c.tga = tga;
        c.len = len; c.dseed = dseed; c.waitc = waitc;
        cmd_q.push_back(c);
    endtask

    task automatic clr_obs();
        obs_adr.delete();
        cyc_cnt   = 0;
        pulse_cnt = 0;
        err_cnt   = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((cmd_q.size() != 0 || exp_cyc || exp_valid) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, 32'(cmd_q.size() == 0 && !exp_cyc && !exp_valid), 32'd1);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single read, zero-wait slave.
        clr_obs();
        push(1'b0, 32'h10, 4'hF, 1'b1, 4'd0, 32'h0, 0);
        wait_done("single_done", 200);
        chk("single_pulses", 32'(pulse_cnt), 32'd1);
        chk("single_cyc_cycles", 32'(cyc_cnt), 32'd1);
        chk("single_dat", last_dat, 32'h5A5A_1224);
        chk("single_adr", obs_adr[0], 32'h10);

        // Four-beat write burst, continuous cyc.
        clr_obs();
        push(1'b1, 32'h100, 4'hF, 1'b0, 4'd3, 32'hA5A5_0000, 0);
        wait_done("burst_done", 200);
        chk("burst_pulses", 32'(pulse_cnt), 32'd4);
        chk("burst_cyc_cycles", 32'(cyc_cnt), 32'd4);
        chk("burst_adr0", obs_adr[0], 32'h100);
        chk("burst_adr1", obs_adr[1], 32'h104);
        chk("burst_adr2", obs_adr[2], 32'h108);
        chk("burst_adr3", obs_adr[3], 32'h10C);
        chk("burst_ram_10c", mem_rd(32'h10C), 32'hA5A5_0003);

        // Three wait states per beat.
        clr_obs();
        push(1'b0, 32'h200, 4'h3, 1'b0, 4'd1, 32'h0, 3);
        wait_done("wait_done", 200);
        chk("wait_pulses", 32'(pulse_cnt), 32'd2);
        chk("wait_cyc_cycles", 32'(cyc_cnt), 32'd8);
        chk("wait_beats", 32'(obs_adr.size()), 32'd2);

        // Address wrap through zero.
        clr_obs();
        push(1'b0, 32'hFFFF_FFF8, 4'hF, 1'b1, 4'd2, 32'h0, 0);
        wait_done("wrap_done", 200);
        chk("wrap_adr0", obs_adr[0], 32'hFFFF_FFF8);
        chk("wrap_adr1", obs_adr[1], 32'hFFFF_FFFC);
        chk("wrap_adr2", obs_adr[2], 32'h0000_0000);

`ifdef WBM_TIMEOUT_EN
        // Silent slave: abort after TMO cycles with an error pulse.
        clr_obs();
        push(1'b0, 32'h300, 4'hF, 1'b0, 4'd2, 32'h0, NOACK);
        wait_done("tmo_done", 200);
        chk("tmo_cyc_cycles", 32'(cyc_cnt), 32'd8);
        chk("tmo_pulses", 32'(pulse_cnt), 32'd1);
        chk("tmo_err_pulses", 32'(err_cnt), 32'd1);
        chk("tmo_beats", 32'(obs_adr.size()), 32'd0);

        // Ack in the expiry cycle completes the beat normally.
        clr_obs();
        push(1'b0, 32'h340, 4'hF, 1'b0, 4'd0, 32'h0, 7);
        wait_done("ackwin_done", 200);
        chk("ackwin_err_pulses", 32'(err_cnt), 32'd0);
        chk("ackwin_pulses", 32'(pulse_cnt), 32'd1);
        chk("ackwin_cyc_cycles", 32'(cyc_cnt), 32'd8);
`endif

        // Asynchronous reset while beat 2 of a write burst is on the bus.
        push(1'b1, 32'h400, 4'hF, 1'b0, 4'd5, 32'h1234_0000, 1);
        n = 0;
        while ((beat_idx != 2 || !exp_cyc) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("rst_reached_beat2", 32'(beat_idx == 2 && exp_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_cyc", 32'(wb_cyc_o), 32'd0);
        chk("async_stb", 32'(wb_stb_o), 32'd0);
        chk("async_valid", 32'(rsp_valid_o), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        clr_obs();
        push(1'b0, 32'h404, 4'hF, 1'b0, 4'd0, 32'h0, 0);
        wait_done("post_rst_done", 200);
        chk("post_rst_pulses", 32'(pulse_cnt), 32'd1);
        chk("post_rst_dat", last_dat, 32'h1234_0001);

        // Randomized commands.
        for (int k = 0; k < 40; k++) begin
            int w;
            w = int'($urandom_range(0, 3));
`ifdef WBM_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) w = NOACK;
`endif
            push(1'($urandom_range(0, 1)), {20'h0, 12'($urandom)} ^ (($urandom_range(0, 7) == 0) ? 32'hFFFF_F000 : 32'h0),
                 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), $urandom, w);
        end
        wait_done("random_done", 8000);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
